// File: rtl/adpll_div_pkg.sv
// Shared types and constants for the ADPLL fractional-N feedback divider.
// The fractional accumulator is built only when FRAC_DIV_EN is defined.
package adpll_div_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } div_state_t;

  localparam int          DEF_N_W   = 8;
  localparam int          DEF_F_W   = 16;
  localparam int unsigned MIN_RATIO = 2;

  // Ratios below 2 cannot produce a high and a low phase, so they are raised to 2.
  function automatic int unsigned clamp_ratio(input int unsigned n);
    return (n < MIN_RATIO) ? MIN_RATIO : n;
  endfunction

endpackage

// File: rtl/frac_accum.sv
// First-order fractional accumulator. The carry is combinational from the
// current accumulator value and the fraction, so the divider can use it on
// the same edge that commits the new accumulator value.
module frac_accum
  import adpll_div_pkg::*;
#(
  parameter int F_W = DEF_F_W
) (
  input  logic           clk_in,
  input  logic           reset,
  input  logic           step,
  input  logic [F_W-1:0] frac,
  output logic           carry
);

  logic [F_W-1:0] acc;
  logic [F_W:0]   sum;

  // Add with carry-out; the sum wraps modulo 2^F_W.
  always_comb begin
    sum   = {1'b0, acc} + {1'b0, frac};
    carry = sum[F_W];
  end

  // Commit the wrapped sum once per output period.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (step) begin
      acc <= sum[F_W-1:0];
    end
  end

endmodule

// File: rtl/frac_divider.sv
// Runtime-programmable fractional-N feedback divider (DCO -> TDC/phase detector).
// Average ratio N + F/2^F_W; each output period is N or N+1 input cycles.
// Define FRAC_DIV_EN to build the fractional accumulator; without it the
// block is an integer-only divider and div_frac is ignored.
//
// Config handshake: a config transfers on any rising clk_in edge where
// cfg_valid && cfg_ready. cfg_ready is high in IDLE and, in RUN, whenever no
// config is pending. A config taken in RUN waits in the pending slot and is
// applied on the first period boundary after the transfer edge, so the
// current period is never truncated or extended.
module frac_divider
  import adpll_div_pkg::*;
#(
  parameter int N_W = DEF_N_W,
  parameter int F_W = DEF_F_W
) (
  input  logic           clk_in,
  input  logic           reset,
  input  logic [N_W-1:0] div_int,
  input  logic [F_W-1:0] div_frac,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  output logic           clk_out,
  output logic           tick
);

  div_state_t     state;
  div_state_t     state_nx;

  logic [N_W:0]   count;
  logic [N_W:0]   m_len;
  logic [N_W:0]   h_len;
  logic [N_W-1:0] act_n;
  logic [N_W-1:0] pend_n;
  logic           pend_valid;

  logic           xfer;
  logic           load_idle;
  logic           boundary;
  logic           step;
  logic           carry;
  logic [N_W-1:0] sel_n;
  logic [N_W:0]   cnt_inc;
  logic [N_W:0]   m_last;
  logic [N_W:0]   new_m;
  logic [N_W:0]   new_h;

`ifdef FRAC_DIV_EN
  logic [F_W-1:0] act_f;
  logic [F_W-1:0] pend_f;
  logic [F_W-1:0] sel_f;
`else
  logic           unused_frac;
`endif

  assign cfg_ready = (state == IDLE) || !pend_valid;

  // Next-state: leave IDLE on the first accepted config; only reset returns to IDLE.
  always_comb begin
    state_nx = state;
    if (state == IDLE && xfer) begin
      state_nx = RUN;
    end
  end

  // State register.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Period control: which ratio starts the next period and how long it is.
  always_comb begin
    xfer      = cfg_valid && cfg_ready;
    load_idle = (state == IDLE) && xfer;
    cnt_inc   = count + {{N_W{1'b0}}, 1'b1};
    m_last    = m_len - {{N_W{1'b0}}, 1'b1};
    boundary  = (state == RUN) && (count == m_last);
    step      = load_idle || boundary;
    if (load_idle) begin
      sel_n = div_int;
    end else if (pend_valid) begin
      sel_n = pend_n;
    end else begin
      sel_n = act_n;
    end
    // N + carry is formed in N_W+1 bits so N = 2^N_W-1 plus a carry cannot wrap.
    new_m = (N_W+1)'(clamp_ratio(32'(sel_n))) + {{N_W{1'b0}}, carry};
    new_h = new_m - (new_m >> 1);
  end

`ifdef FRAC_DIV_EN
  // Fraction feeding the accumulator follows the same selection as the ratio.
  always_comb begin
    if (load_idle) begin
      sel_f = div_frac;
    end else if (pend_valid) begin
      sel_f = pend_f;
    end else begin
      sel_f = act_f;
    end
  end

  frac_accum #(
    .F_W (F_W)
  ) u_frac_accum (
    .clk_in (clk_in),
    .reset  (reset),
    .step   (step),
    .frac   (sel_f),
    .carry  (carry)
  );

  // Active/pending fraction registers, updated alongside the integer ratio.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      act_f  <= '0;
      pend_f <= '0;
    end else begin
      if (load_idle || (boundary && pend_valid)) begin
        act_f <= sel_f;
      end
      if (state == RUN && xfer) begin
        pend_f <= div_frac;
      end
    end
  end
`else
  // Integer-only build: no accumulator, every period is exactly N.
  assign carry       = 1'b0;
  assign unused_frac = ^{div_frac, step};
`endif

  // Counter, period/phase lengths, ratio registers and registered outputs.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      count      <= '0;
      m_len      <= '0;
      h_len      <= '0;
      act_n      <= '0;
      pend_n     <= '0;
      pend_valid <= 1'b0;
      clk_out    <= 1'b0;
      tick       <= 1'b0;
    end else begin
      if (load_idle) begin
        act_n   <= div_int;
        m_len   <= new_m;
        h_len   <= new_h;
        count   <= '0;
        clk_out <= 1'b1;
        tick    <= 1'b1;
      end else if (state == RUN) begin
        if (boundary) begin
          if (pend_valid) begin
            act_n      <= pend_n;
            pend_valid <= 1'b0;
          end
          m_len   <= new_m;
          h_len   <= new_h;
          count   <= '0;
          clk_out <= 1'b1;
          tick    <= 1'b1;
        end else begin
          count   <= cnt_inc;
          clk_out <= (cnt_inc < h_len);
          tick    <= 1'b0;
        end
        // A transfer in RUN only happens with the pending slot empty, so it
        // never collides with the boundary clearing pend_valid.
        if (xfer) begin
          pend_n     <= div_int;
          pend_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_frac_divider.sv
// Self-checking bench for frac_divider. The reference model describes each
// output period as a list of (clk_out, tick) samples derived from the ratio
// rules; expected samples are popped one per input cycle.
module tb_frac_divider;

  localparam int N_W = 8;
  localparam int F_W = 16;

  // Clock / reset
  logic           clk_in = 1'b0;
  logic           reset;
  logic [N_W-1:0] div_int;
  logic [F_W-1:0] div_frac;
  logic           cfg_valid;
  logic           cfg_ready;
  logic           clk_out;
  logic           tick;

  always #5 clk_in = ~clk_in;

  frac_divider #(
    .N_W (N_W),
    .F_W (F_W)
  ) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .div_int   (div_int),
    .div_frac  (div_frac),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  // Scoreboard and reference model
  int checks = 0;
  int errors = 0;
  int tick_cnt = 0;

  logic [1:0] exp_q[$];
  bit         m_run;
  bit         m_pend;
  int         m_an, m_af, m_pn, m_pf, m_acc;
  logic       exp_clk, exp_tick;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_run    = 1'b0;
    m_pend   = 1'b0;
    m_acc    = 0;
    m_an     = 0;
    m_af     = 0;
    exp_q.delete();
    exp_clk  = 1'b0;
    exp_tick = 1'b0;
  endfunction

  // One output period: ceil(M/2) high samples then floor(M/2) low, tick on the first.
  function automatic void start_period();
    int c = 0;
    int m;
`ifdef FRAC_DIV_EN
    int s;
    s     = m_acc + m_af;
    c     = s / (1 << F_W);
    m_acc = s % (1 << F_W);
`endif
    m = ((m_an < 2) ? 2 : m_an) + c;
    for (int i = 0; i < m; i++) begin
      exp_q.push_back({(i < (m + 1) / 2), (i == 0)});
    end
  endfunction

  function automatic void model_step(input bit xfer, input int n, input int f);
    if (!m_run) begin
      if (xfer) begin
        m_an  = n;
        m_af  = f;
        m_run = 1'b1;
        start_period();
      end
    end else begin
      if (exp_q.size() == 0) begin
        if (m_pend) begin
          m_an   = m_pn;
          m_af   = m_pf;
          m_pend = 1'b0;
        end
        start_period();
      end
      if (xfer) begin
        m_pn   = n;
        m_pf   = f;
        m_pend = 1'b1;
      end
    end
    if (m_run) begin
      {exp_clk, exp_tick} = exp_q.pop_front();
    end
  endfunction

  // Driver: check current outputs, drive inputs, advance one clk_in edge.
  task automatic cycle(input bit v, input int n, input int f);
    bit xfer;
    int nm;
    int fm;
    nm = n % (1 << N_W);
    fm = f % (1 << F_W);
    check("clk_out", 32'(clk_out), 32'(exp_clk));
    check("tick", 32'(tick), 32'(exp_tick));
    check("cfg_ready", 32'(cfg_ready), 32'(!m_run || !m_pend));
    if (tick === 1'b1) tick_cnt++;
    cfg_valid = v;
    div_int   = nm[N_W-1:0];
    div_frac  = fm[F_W-1:0];
    xfer      = v && (!m_run || !m_pend);
    @(posedge clk_in);
    model_step(xfer, nm, fm);
    @(negedge clk_in);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) cycle(1'b0, 0, 0);
  endtask

  // Advance until the model shows `left` samples remaining in a running period.
  task automatic wait_left(input int left, input string tag);
    int budget = 300;
    while (!(m_run && exp_q.size() == left) && budget > 0) begin
      cycle(1'b0, 0, 0);
      budget--;
    end
    check(tag, 32'(budget > 0), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    reset = 1'b1;
    #1;
    model_reset();
    check("rst_clk_out", 32'(clk_out), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    @(negedge clk_in);
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    cfg_valid = 1'b0;
    div_int   = '0;
    div_frac  = '0;
    model_reset();
    repeat (2) @(negedge clk_in);
    check("rst_clk_out", 32'(clk_out), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    reset = 1'b0;
    idle(3);

    // Integer ratio 8: first rise one edge after the transfer
    cycle(1'b1, 8, 0);
    check("first_rise", 32'(clk_out), 32'd1);
    check("first_tick", 32'(tick), 32'd1);
    idle(40);

    // Odd ratio 5, then ratio 1 treated as 2, then 0 treated as 2
    cycle(1'b1, 5, 0);
    idle(30);
    cycle(1'b1, 1, 0);
    idle(20);
    cycle(1'b1, 0, 0);
    idle(20);

    // Reload: N=8 running, new N=3 at count=2; cfg_valid held high afterwards
    do_reset();
    cycle(1'b1, 8, 0);
    wait_left(5, "reload_wait");
    cycle(1'b1, 3, 0);
    check("ready_low_after_xfer", 32'(cfg_ready), 32'd0);
    for (int i = 0; i < 12; i++) cycle(1'b1, 6, 0);
    idle(30);

    // Boundary collision: transfer on the edge where count = M-1
    wait_left(0, "boundary_wait");
    cycle(1'b1, 4, 0);
    idle(30);

    // Reset mid-period at count=3 of N=8
    do_reset();
    cycle(1'b1, 8, 0);
    wait_left(4, "midrst_wait");
    do_reset();
    idle(12);

    // N=4, F=0x4000 from a cleared accumulator: ticks over 400 cycles
    cycle(1'b1, 4, 16'h4000);
    tick_cnt = 0;
    idle(400);
`ifdef FRAC_DIV_EN
    check("avg_ticks", 32'(tick_cnt), 32'd95);
`else
    check("avg_ticks", 32'(tick_cnt), 32'd100);
`endif

    // Randomized configs and handshake timing
    for (int i = 0; i < 2000; i++) begin
      int n;
      n = ($urandom_range(0, 49) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12);
      if ($urandom_range(0, 3) == 0) begin
        cycle(1'b1, n, $urandom_range(0, 65535));
      end else begin
        cycle(1'b0, n, $urandom_range(0, 65535));
      end
    end

    // Report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
